// File: rtl/iob_split_tracked.sv
// rtl/iob_split_tracked.sv - IOb 1-to-N splitter with in-order read tracking, error responder and slave timeout
module iob_split_tracked #(
    parameter int          ADDR_W          = 32,
    parameter int          DATA_W          = 32,
    parameter int          N_SLAVES        = 4,
    parameter int          P_SLAVES        = 27,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          TIMEOUT_W       = 8,
    parameter logic [31:0] ERR_DATA        = 32'hDEADBEEF
) (
    input  logic                             clk_i,
    input  logic                             arst_i,
    input  logic                             cke_i,
    input  logic                             m_avalid_i,
    input  logic [ADDR_W-1:0]                m_addr_i,
    input  logic [DATA_W-1:0]                m_wdata_i,
    input  logic [DATA_W/8-1:0]              m_wstrb_i,
    output logic                             m_ready_o,
    output logic                             m_rvalid_o,
    output logic [DATA_W-1:0]                m_rdata_o,
    output logic [N_SLAVES-1:0]              s_avalid_o,
    output logic [ADDR_W-1:0]                s_addr_o,
    output logic [DATA_W-1:0]                s_wdata_o,
    output logic [DATA_W/8-1:0]              s_wstrb_o,
    input  logic [N_SLAVES-1:0]              s_ready_i,
    input  logic [N_SLAVES-1:0]              s_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0]       s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic [N_SLAVES-1:0]              dead_o,
    output logic                             err_o
);

    localparam int SEL_W = $clog2(N_SLAVES);
    localparam int CUR_W = $clog2(N_SLAVES + 1);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    // Index N_SLAVES stands for the internal error responder
    localparam logic [CUR_W-1:0]  ERR_IDX  = CUR_W'(N_SLAVES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FLUSH
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_next;
    logic [CUR_W-1:0]     cur_q;
    logic [CUR_W-1:0]     target;
    logic [N_SLAVES-1:0]  dead_q;
    logic [TIMEOUT_W-1:0] timer_q;
    logic                 err_rd_q;
    logic                 err_q;

    logic [SEL_W-1:0]     sel;
    logic                 sel_valid;
    logic                 sel_dead;
    logic                 sel_ready;
    logic                 err_tgt;
    logic                 is_read;
    logic                 gate;
    logic                 accept;
    logic                 acc_rd;

    logic                 cur_real;
    logic                 cur_rvalid;
    logic                 cur_dead;
    logic [DATA_W-1:0]    cur_rdata;
    logic                 slv_resp;
    logic                 flush_resp;
    logic                 timer_run;
    logic                 fire;

    assign sel       = m_addr_i[P_SLAVES -: SEL_W];
    assign is_read   = (m_wstrb_i == '0);

    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;
    assign s_wstrb_o = m_wstrb_i;

    // Look up the addressed slave; a select with no matching slave is unmapped
    always_comb begin
        sel_valid = 1'b0;
        sel_dead  = 1'b0;
        sel_ready = 1'b0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_valid = 1'b1;
                sel_dead  = dead_q[k];
                sel_ready = s_ready_i[k];
            end
        end
    end

    assign err_tgt = ~sel_valid | sel_dead;
    assign target  = err_tgt ? ERR_IDX : CUR_W'(sel);

    // Admission: reads only join an existing in-flight stream to the same target
    always_comb begin
        gate = 1'b0;
        case (state_q)
            IDLE:    gate = 1'b1;
            BUSY:    gate = is_read ? ((target == cur_q) && (cnt_q < CNT_MAX)) : 1'b1;
            default: gate = 1'b0;
        endcase
        gate = gate & cke_i;
    end

    // Forward the request valid only to a live, mapped slave
    always_comb begin
        s_avalid_o = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            s_avalid_o[k] = m_avalid_i & gate & ~err_tgt & (sel == SEL_W'(k));
        end
    end

    assign m_ready_o = gate & (err_tgt | sel_ready);
    assign accept    = m_avalid_i & m_ready_o;
    assign acc_rd    = accept & is_read;

    // Select the response signals of the slave that owns the in-flight reads
    always_comb begin
        cur_rvalid = 1'b0;
        cur_dead   = 1'b0;
        cur_rdata  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (cur_q == CUR_W'(k)) begin
                cur_rvalid = s_rvalid_i[k];
                cur_dead   = dead_q[k];
                cur_rdata  = s_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign cur_real   = (cur_q != ERR_IDX);
    assign slv_resp   = (state_q == BUSY) & cur_real & (cnt_q != '0) & cur_rvalid & ~cur_dead;
    assign flush_resp = (state_q == FLUSH) & (cnt_q != '0);
    assign m_rvalid_o = slv_resp | err_rd_q | flush_resp;

    // Response data is zero whenever no response is presented
    always_comb begin
        m_rdata_o = '0;
        if (slv_resp) begin
            m_rdata_o = cur_rdata;
        end else if (err_rd_q || flush_resp) begin
            m_rdata_o = ERR_WORD;
        end
    end

    assign timer_run = (state_q == BUSY) & cur_real & (cnt_q != '0) & ~m_rvalid_o & ~accept;
    assign fire      = timer_run & (timer_q == '1);

    // Outstanding count: accept and response in the same cycle cancel out
    always_comb begin
        cnt_next = cnt_q;
        if (acc_rd && !m_rvalid_o) begin
            cnt_next = cnt_q + CNT_W'(1);
        end else if (!acc_rd && m_rvalid_o) begin
            cnt_next = cnt_q - CNT_W'(1);
        end
    end

    // Tracking state machine: counter, owner, timeout, dead flags and error pulse
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cur_q    <= '0;
            dead_q   <= '0;
            timer_q  <= '0;
            err_rd_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (cke_i) begin
            cnt_q    <= cnt_next;
            err_rd_q <= acc_rd & err_tgt;
            err_q    <= (accept & err_tgt) | fire;
            if (acc_rd) begin
                cur_q <= target;
            end
            if (timer_run && !fire) begin
                timer_q <= timer_q + TIMEOUT_W'(1);
            end else begin
                timer_q <= '0;
            end
            for (int k = 0; k < N_SLAVES; k++) begin
                if (fire && (cur_q == CUR_W'(k))) begin
                    dead_q[k] <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (acc_rd) begin
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (fire) begin
                        state_q <= FLUSH;
                    end else if (cnt_next == '0) begin
                        state_q <= IDLE;
                    end
                end
                FLUSH: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign outstanding_o = cnt_q;
    assign dead_o        = dead_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_iob_split_tracked.sv
// tb/tb_iob_split_tracked.sv - directed scoreboard bench for iob_split_tracked
module tb_iob_split_tracked;

    localparam int          NS   = 3;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              cke;
    logic              m_avalid_i;
    logic [AW-1:0]     m_addr_i;
    logic [DW-1:0]     m_wdata_i;
    logic [DW/8-1:0]   m_wstrb_i;
    logic              m_ready_o;
    logic              m_rvalid_o;
    logic [DW-1:0]     m_rdata_o;
    logic [NS-1:0]     s_avalid_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_wdata_o;
    logic [DW/8-1:0]   s_wstrb_o;
    logic [NS-1:0]     s_ready_i;
    logic [NS-1:0]     s_rvalid_i;
    logic [NS*DW-1:0]  s_rdata_i;
    logic [2:0]        outstanding_o;
    logic [NS-1:0]     dead_o;
    logic              err_o;

    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    int          total = 0;
    int          bad   = 0;

    iob_split_tracked #(
        .N_SLAVES  (NS),
        .TIMEOUT_W (4)
    ) dut (
        .clk_i         (clk),
        .arst_i        (rst),
        .cke_i         (cke),
        .m_avalid_i    (m_avalid_i),
        .m_addr_i      (m_addr_i),
        .m_wdata_i     (m_wdata_i),
        .m_wstrb_i     (m_wstrb_i),
        .m_ready_o     (m_ready_o),
        .m_rvalid_o    (m_rvalid_o),
        .m_rdata_o     (m_rdata_o),
        .s_avalid_o    (s_avalid_o),
        .s_addr_o      (s_addr_o),
        .s_wdata_o     (s_wdata_o),
        .s_wstrb_o     (s_wstrb_o),
        .s_ready_i     (s_ready_i),
        .s_rvalid_i    (s_rvalid_i),
        .s_rdata_i     (s_rdata_i),
        .outstanding_o (outstanding_o),
        .dead_o        (dead_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addr_of(input int sel);
        return (32'(sel) << 26) | 32'h0000_0100;
    endfunction

    // Present one request and hold it until accepted or max_wait cycles pass
    task automatic req(input int sel, input bit wr, input logic [31:0] d, input bit push,
                       input int max_wait, output int waited, output logic [NS-1:0] av);
        bit acc;
        acc        = 1'b0;
        waited     = 0;
        av         = '0;
        m_avalid_i = 1'b1;
        m_addr_i   = addr_of(sel);
        m_wstrb_i  = wr ? 4'hF : 4'h0;
        m_wdata_i  = wr ? d : 32'h0;
        for (int i = 0; i <= max_wait; i++) begin
            @(negedge clk);
            if (m_ready_o) begin
                acc = 1'b1;
                av  = s_avalid_o;
                if (!wr && push) exp_q.push_back(d);
                break;
            end
            waited++;
        end
        if (!acc) chk("req_accept", m_ready_o, 1'b1);
        @(posedge clk);
        #1;
        m_avalid_i = 1'b0;
    endtask

    task automatic slave_resp(input int k, input logic [31:0] d);
        s_rdata_i[k*DW +: DW] = d;
        s_rvalid_i[k]         = 1'b1;
        tick();
        s_rvalid_i[k]         = 1'b0;
    endtask

    // Scoreboard: every response must match the oldest expected read
    always @(negedge clk) begin
        if (!rst && m_rvalid_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rvalid", m_rvalid_o, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", m_rdata_o, mon_e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int            w;
        int            n;
        bit            seen;
        logic [NS-1:0] av;

        rst        = 1'b1;
        cke        = 1'b1;
        m_avalid_i = 1'b0;
        m_addr_i   = '0;
        m_wdata_i  = '0;
        m_wstrb_i  = '0;
        s_ready_i  = '1;
        s_rvalid_i = '0;
        s_rdata_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_rvalid", m_rvalid_o, 0);
        chk("rst_rdata", m_rdata_o, 0);
        chk("rst_dead", dead_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_savalid", s_avalid_o, 0);
        tick();
        rst = 1'b0;

        // Single read to slave 1, answered three cycles later
        req(1, 1'b0, 32'h12345678, 1'b1, 4, w, av);
        chk("A_wait", w, 0);
        chk("A_savalid", av, 3'b010);
        @(negedge clk);
        chk("A_out1", outstanding_o, 1);
        tick();
        tick();
        slave_resp(1, 32'h12345678);
        @(negedge clk);
        chk("A_out0", outstanding_o, 0);
        chk("A_rv_once", m_rvalid_o, 0);
        tick();

        // Four pipelined reads to slave 2, fifth held at the limit
        for (int i = 1; i <= 4; i++) begin
            req(2, 1'b0, 32'(i), 1'b1, 2, w, av);
            chk("B_wait", w, 0);
        end
        @(negedge clk);
        chk("B_out4", outstanding_o, 4);
        m_avalid_i = 1'b1;
        m_addr_i   = addr_of(2);
        m_wstrb_i  = 4'h0;
        repeat (2) begin
            @(negedge clk);
            chk("B_hold", m_ready_o, 0);
        end
        @(posedge clk);
        #1;
        s_rdata_i[2*DW +: DW] = 32'd1;
        s_rvalid_i[2]         = 1'b1;
        @(negedge clk);
        chk("B_no_bypass", m_ready_o, 0);
        @(posedge clk);
        #1;
        s_rvalid_i[2] = 1'b0;
        @(negedge clk);
        chk("B_fifth_ready", m_ready_o, 1);
        if (m_ready_o) exp_q.push_back(32'd5);
        @(posedge clk);
        #1;
        m_avalid_i = 1'b0;
        @(negedge clk);
        chk("B_out_refill", outstanding_o, 4);
        @(posedge clk);
        #1;
        for (int i = 2; i <= 5; i++) slave_resp(2, 32'(i));
        @(negedge clk);
        chk("B_out0", outstanding_o, 0);
        tick();

        // Read to another slave stalls behind slave 0; a write passes
        req(0, 1'b0, 32'h0A0A0A0A, 1'b1, 2, w, av);
        chk("C_rd0_wait", w, 0);
        m_avalid_i = 1'b1;
        m_addr_i   = addr_of(2);
        m_wstrb_i  = 4'h0;
        repeat (2) begin
            @(negedge clk);
            chk("C_stall_ready", m_ready_o, 0);
            chk("C_stall_av", s_avalid_o, 0);
        end
        @(posedge clk);
        #1;
        m_wstrb_i = 4'hF;
        m_wdata_i = 32'h55;
        @(negedge clk);
        chk("C_wr_ready", m_ready_o, 1);
        chk("C_wr_av", s_avalid_o, 3'b100);
        @(posedge clk);
        #1;
        m_wstrb_i = 4'h0;
        @(negedge clk);
        chk("C_stall_again", m_ready_o, 0);
        chk("C_out_after_wr", outstanding_o, 1);
        @(posedge clk);
        #1;
        slave_resp(0, 32'h0A0A0A0A);
        req(2, 1'b0, 32'h0B0B0B0B, 1'b1, 3, w, av);
        chk("C_rd2_wait", w, 0);
        chk("C_rd2_av", av, 3'b100);
        tick();
        slave_resp(2, 32'h0B0B0B0B);
        @(negedge clk);
        chk("C_out0", outstanding_o, 0);
        tick();

        // Unmapped select 3: error read and error write
        req(3, 1'b0, ERRD, 1'b1, 2, w, av);
        chk("D_rd_wait", w, 0);
        chk("D_rd_av", av, 0);
        @(negedge clk);
        chk("D_rd_err", err_o, 1);
        chk("D_rd_rv", m_rvalid_o, 1);
        @(negedge clk);
        chk("D_err_clear", err_o, 0);
        chk("D_out0", outstanding_o, 0);
        tick();
        req(3, 1'b1, 32'h77, 1'b0, 2, w, av);
        chk("D_wr_wait", w, 0);
        chk("D_wr_av", av, 0);
        @(negedge clk);
        chk("D_wr_err", err_o, 1);
        chk("D_wr_norv", m_rvalid_o, 0);
        tick();

        // Two unanswered reads to slave 1 time out and flush
        req(1, 1'b0, ERRD, 1'b1, 2, w, av);
        req(1, 1'b0, ERRD, 1'b1, 2, w, av);
        chk("E_wait", w, 0);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (err_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("E_err_seen", seen, 1);
        chk("E_delay_in_window", (n >= 16) && (n <= 17), 1);
        chk("E_dead", dead_o, 3'b010);
        chk("E_flush_rv0", m_rvalid_o, 1);
        @(negedge clk);
        chk("E_flush_rv1", m_rvalid_o, 1);
        chk("E_err_once", err_o, 0);
        @(negedge clk);
        chk("E_flush_done", m_rvalid_o, 0);
        chk("E_out0", outstanding_o, 0);
        @(posedge clk);
        #1;
        slave_resp(1, 32'h99999999);
        req(1, 1'b0, ERRD, 1'b1, 2, w, av);
        chk("E_dead_rd_wait", w, 0);
        chk("E_dead_rd_av", av, 0);
        @(negedge clk);
        chk("E_dead_rd_rv", m_rvalid_o, 1);
        chk("E_dead_rd_err", err_o, 1);
        tick();

        // Reset with reads in flight discards them
        for (int i = 0; i < 3; i++) req(0, 1'b0, 32'h0, 1'b0, 2, w, av);
        @(negedge clk);
        chk("F_out3", outstanding_o, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("F_rst_out", outstanding_o, 0);
        chk("F_rst_dead", dead_o, 0);
        chk("F_rst_rv", m_rvalid_o, 0);
        @(posedge clk);
        #1;
        rst                   = 1'b0;
        s_rdata_i[0 +: DW]    = 32'h11111111;
        s_rvalid_i[0]         = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("F_no_rv", m_rvalid_o, 0);
        end
        @(posedge clk);
        #1;
        s_rvalid_i[0] = 1'b0;
        tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_split_tracked.md
Name: iob_split_tracked

Overview:
- Parametrised successor to the peripheral bus splitter: one IOb master port fans out to N_SLAVES IOb slave ports, selected by an address field.
- Adds outstanding-read tracking up to MAX_OUTSTANDING, in-order response steering and error responses for unmapped slaves.
- Adds a per-read timeout that flushes pending reads and sticky-disables a hung slave.
- Sits between the AXI-Lite-to-IOb bridge and the peripherals (boot controller, UART, CLINT, PLIC, ...).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- N_SLAVES, 4, number of slave ports (>=2).
- P_SLAVES, 27, MSB bit index of the select field; field is addr[P_SLAVES -: SEL_W], SEL_W=$clog2(N_SLAVES).
- MAX_OUTSTANDING, 4, maximum in-flight reads (power of 2, >=1).
- TIMEOUT_W, 8, width of the timeout counter; timeout fires at 2**TIMEOUT_W-1 idle cycles.
- ERR_DATA, 32'hDEADBEEF, rdata returned on error responses (truncated/zero-extended to DATA_W).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous reset, active-high.
- cke_i  in  1  clock enable; all registers hold when low.
- m_avalid_i  in  1  master request valid.
- m_addr_i  in  ADDR_W  master address.
- m_wdata_i  in  DATA_W  write data.
- m_wstrb_i  in  DATA_W/8  write strobe; 0 = read.
- m_ready_o  out  1  request accepted when m_avalid_i & m_ready_o.
- m_rvalid_o  out  1  read response valid.
- m_rdata_o  out  DATA_W  read data.
- s_avalid_o  out  N_SLAVES  per-slave request valid.
- s_addr_o  out  ADDR_W  shared address.
- s_wdata_o  out  DATA_W  shared write data.
- s_wstrb_o  out  DATA_W/8  shared strobe.
- s_ready_i  in  N_SLAVES  per-slave ready.
- s_rvalid_i  in  N_SLAVES  per-slave rvalid.
- s_rdata_i  in  N_SLAVES*DATA_W  per-slave rdata; slave k at [k*DATA_W +: DATA_W].
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current in-flight read count.
- dead_o  out  N_SLAVES  sticky hung-slave flags.
- err_o  out  1  one-cycle pulse on each error event.

Behaviour:
- Reset: cnt=0, cur=0, state=IDLE, dead=0, timer=0, err_o=0, m_rvalid_o=0, m_rdata_o=0, outstanding_o=0.
- Decode: sel=addr field. Target is "error" if sel>=N_SLAVES or dead[sel]; otherwise target is slave sel.
- Request path is combinational: s_addr/wdata/wstrb = m_* always. s_avalid_o[sel] = m_avalid_i & gate for a valid target, else 0. m_ready_o = gate & (error target ? 1 : s_ready_i[sel]).
- State IDLE (cnt==0): gate=1.
- State BUSY (cnt>0): read gate = (target==cur) & (cnt<MAX_OUTSTANDING); write gate=1.
  - A read to a different target stalls until cnt returns to 0.
  - No same-cycle bypass when cnt==MAX_OUTSTANDING.
- Accepting a read sets cur=target (error target encoded as index N_SLAVES) and increments cnt. Writes never touch cnt. Accepted writes to an error target are dropped and pulse err_o.
- Response steering:
  - If cur is a real slave: m_rvalid_o = (cnt>0) & s_rvalid_i[cur] & ~dead[cur], m_rdata_o = s_rdata_i[cur].
  - If cur==N_SLAVES: an internal responder asserts m_rvalid_o with ERR_DATA and pulses err_o exactly 1 cycle after each accepted error read.
- Every m_rvalid_o decrements cnt. Accept and response in the same cycle leave cnt unchanged. rvalid from any non-cur slave, or with cnt==0, is ignored.
- Timeout: in BUSY with cur a real slave, timer increments each cycle and clears on a response, an accept or cnt==0. When timer reaches 2**TIMEOUT_W-1: state=FLUSH, dead[cur]=1, err_o pulse.
- FLUSH: gate=0. Emit one m_rvalid_o (ERR_DATA) per cycle, decrementing cnt. When cnt reaches 0 go to IDLE. Late s_rvalid_i from a dead slave are ignored.
- dead bits clear only on arst_i. Reset mid-transaction discards all pending reads with no response.
- outstanding_o=cnt.

Test Plan:
- Read slave 1 (addr field=1), slave answers 3 cycles later with 32'h12345678 -> m_ready_o=1 on accept, outstanding_o 1->0, m_rvalid_o=1 with m_rdata_o=32'h12345678 for one cycle.
- 4 back-to-back reads to slave 2 with slave rvalid withheld -> 4 accepted, 5th held m_ready_o=0 until first rvalid; responses return in order with data 1,2,3,4.
- Read slave 0 pending, then read to slave 3 -> slave-3 request stalls (s_avalid_o[3]=0) until slave-0 rvalid; meanwhile a write to slave 3 is accepted immediately.
- With N_SLAVES=4 and SEL_W=2 all indices are valid, so use N_SLAVES=3 and read sel=3 -> accepted the same cycle, m_rvalid_o next cycle with 32'hDEADBEEF, err_o=1; write sel=3 -> accepted, err_o=1, no rvalid.
- TIMEOUT_W=4, 2 reads to slave 1 never answered -> after 15 idle cycles err_o=1, dead_o[1]=1, two ERR_DATA responses on consecutive cycles; a later read to slave 1 returns ERR_DATA next cycle and s_avalid_o[1] stays 0.
- arst_i pulsed with 3 reads outstanding -> outstanding_o=0, dead_o=0, no m_rvalid_o afterwards even if slave rvalids arrive.
